adc_sample_conditioner: RTL
===========================

// Module: adc_sample_conditioner
// PURPOSE
//  Source end of the NLC sample interface: buffers raw ADC codes, centres (subtract offset) and scales them,
//  then issues one x_centered_scaled word with a 1-cycle x_centered_scaled_in_ready pulse to NLC_Processor.
//  Holds the word stable and issues nothing further until NLC returns x_output_ready, so one sample is in flight.
// PARAMETERS
//  ADC_WL      14  raw ADC code width (unsigned)
//  WL          32  output word width (signed two's complement)
//  FRAC_SHIFT  8   arithmetic right shift applied to the product (scale fraction bits)
//  DEPTH       8   input FIFO depth; power of 2, >=2
// PORTS
//  clk                         in   1          system clock, all logic on posedge
//  reset                       in   1          asynchronous, active-low; 0 = in reset
//  adc_data                    in   ADC_WL     raw ADC code, sampled when adc_valid=1
//  adc_valid                   in   1          push request, one sample per cycle max
//  adc_offset                  in   ADC_WL     unsigned centre code; quasi-static, sampled at pop
//  adc_scale                   in   WL         signed scale, FRAC_SHIFT fraction bits; sampled at pop
//  x_output_ready              in   1          NLC done pulse; releases the interface
//  x_centered_scaled           out  WL         conditioned sample to NLC
//  x_centered_scaled_in_ready  out  1          1-cycle pulse: x_centered_scaled is new
//  fifo_count                  out  log2(DEPTH)+1  occupancy, 0..DEPTH
//  overflow                    out  1          sticky: a push was dropped; cleared only by reset
//  saturated                   out  1          1-cycle pulse coincident with in_ready when result clamped
//  busy                        out  1          1 when FSM is not IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, FSM IDLE, all outputs 0; in-flight sample discarded, no pulse issued.
//  FIFO: circular, wrap at DEPTH. Push when adc_valid && (!full || pop this cycle); push and pop in the same cycle
//   at full is accepted, count unchanged. Push at full without pop: sample dropped, overflow<=1.
//  Arithmetic, one pipeline register per stage:
//   S1 diff  = {1'b0,adc_data} - {1'b0,adc_offset}        signed ADC_WL+1 bits, exact
//   S2 prod  = diff * adc_scale                            signed ADC_WL+1+WL bits, exact
//   S3 res   = prod >>> FRAC_SHIFT (floor); if res > 2^(WL-1)-1 -> 2^(WL-1)-1, if < -2^(WL-1) -> -2^(WL-1),
//             set saturated for that sample.
//  FSM states / transitions:
//   IDLE  : fifo non-empty -> pop head, latch offset/scale into S1 -> CALC1
//   CALC1 : S2 -> CALC2
//   CALC2 : S3 result into output register -> ISSUE
//   ISSUE : in_ready=1 for exactly this cycle -> WAIT
//   WAIT  : on x_output_ready=1 -> IDLE; else stay (no timeout)
//  x_output_ready is sampled only in WAIT; pulses in other states are ignored.
//  x_centered_scaled changes only on the CALC2->ISSUE edge; held constant through ISSUE and WAIT
//   (NLC re-reads it every cycle of its polynomial evaluation).
//  Latency: write into empty FIFO at edge T0 with FSM IDLE -> pop at T1, in_ready high in the cycle after edge T4.
//  Throughput: 1 sample per (5 + NLC processing cycles); IDLE->pop same cycle x_output_ready returns to IDLE +1.
//  FIFO keeps accepting samples in every state, including during a mid-operation pop.
// TESTING (ADC_WL=14, WL=32, FRAC_SHIFT=8, DEPTH=8)
//  1 Reset: reset=0 mid-WAIT -> all outputs 0, fifo_count=0, no in_ready after release until a new push.
//  2 offset=8192, scale=256, push 8200 then 8000 -> words 8 then -192 (0xFFFFFF40), second only after x_output_ready.
//  3 offset=0, scale=0x7FFFFFFF, adc=16383 -> 0x7FFFFFFF, saturated=1; offset=16383, adc=0 -> 0x80000000, saturated=1.
//  4 Hold x_output_ready=0, push 10 samples back-to-back -> one issued, 8 buffered,
//    the 10th push dropped (fifo_count=8, overflow=1); all 9 accepted samples later delivered in order.
//  5 Push at full on the exact IDLE pop cycle -> accepted, fifo_count stays 8, overflow stays 0.
//  6 Pulse x_output_ready during IDLE/CALC1/ISSUE -> ignored; x_centered_scaled stable for the whole WAIT.

Source files
------------

// File: rtl/adc_sample_conditioner_if.sv
// NLC sample handshake between the ADC conditioner (master, source of samples) and the
// NLC processor (slave, consumer).
//   x_centered_scaled           master->slave  conditioned sample word, held until released
//   x_centered_scaled_in_ready  master->slave  1-cycle pulse: x_centered_scaled is new
//   x_output_ready              slave->master  NLC done pulse, releases the master for a new word
interface adc_sample_conditioner_if #(
    parameter int unsigned WL = 32
);
    logic [WL-1:0] x_centered_scaled;
    logic          x_centered_scaled_in_ready;
    logic          x_output_ready;

    modport master (
        output x_centered_scaled,
        output x_centered_scaled_in_ready,
        input  x_output_ready
    );

    modport slave (
        input  x_centered_scaled,
        input  x_centered_scaled_in_ready,
        output x_output_ready
    );
endinterface

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: buffers raw ADC codes in a FIFO, centres each one (subtract
// offset), scales it (multiply, arithmetic shift, clamp) and hands one word at a time to the
// NLC processor, holding it until NLC signals x_output_ready.
// Ports:
//   clk, reset        system clock; asynchronous active-low reset
//   adc_data/valid    raw unsigned ADC code and push request
//   adc_offset/scale  centre code and signed scale, sampled when a sample is popped
//   nlc               NLC handshake (master side)
//   fifo_count        FIFO occupancy 0..DEPTH
//   overflow          sticky, a push was dropped at full
//   saturated         pulse alongside in_ready when the result was clamped
//   busy              FSM is not idle
module adc_sample_conditioner #(
    parameter int unsigned ADC_WL     = 14,
    parameter int unsigned WL         = 32,
    parameter int unsigned FRAC_SHIFT = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADC_WL-1:0]         adc_data,
    input  logic                      adc_valid,
    input  logic [ADC_WL-1:0]         adc_offset,
    input  logic [WL-1:0]             adc_scale,
    adc_sample_conditioner_if.master  nlc,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic                      saturated,
    output logic                      busy
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned DiffW = ADC_WL + 1;
    localparam int unsigned ProdW = DiffW + WL;
    localparam int unsigned ResW  = ProdW - FRAC_SHIFT;

    typedef enum logic [2:0] {StIdle, StCalc1, StCalc2, StIssue, StWait} state_e;

    // FIFO
    logic [ADC_WL-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              overflow_q;
    logic              full, pop, push;

    // Pipeline and FSM
    state_e                  state_q;
    logic signed [DiffW-1:0] diff_q;
    logic signed [WL-1:0]    scale_q;
    logic signed [ProdW-1:0] prod_q;
    logic [WL-1:0]           out_q;
    logic                    clip_q;
    logic                    in_ready_q;
    logic                    sat_pulse_q;

    logic signed [DiffW-1:0] head_diff;
    logic signed [ResW-1:0]  res;
    logic [ResW-WL:0]        res_hi;
    logic                    clip_pos, clip_neg;
    logic [WL-1:0]           res_sat;

    assign full = (count_q == (PtrW+1)'(DEPTH));
    assign pop  = (state_q == StIdle) && (count_q != '0);
    // A push at full is still accepted when the same edge frees a slot.
    assign push = adc_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (adc_valid && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign head_diff = {1'b0, mem_q[rd_ptr_q]} - {1'b0, adc_offset};

    // Floor shift; the dropped top bits are sign copies, so truncation is exact.
    assign res      = ResW'(prod_q >>> FRAC_SHIFT);
    assign res_hi   = res[ResW-1:WL-1];
    assign clip_pos = !res[ResW-1] && (|res_hi);
    assign clip_neg =  res[ResW-1] && !(&res_hi);

    always_comb begin
        res_sat = res[WL-1:0];
        if (clip_pos) res_sat = {1'b0, {(WL-1){1'b1}}};
        if (clip_neg) res_sat = {1'b1, {(WL-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            diff_q      <= '0;
            scale_q     <= '0;
            prod_q      <= '0;
            out_q       <= '0;
            clip_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            sat_pulse_q <= 1'b0;
        end else begin
            in_ready_q  <= 1'b0;
            sat_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        diff_q  <= head_diff;
                        scale_q <= adc_scale;
                        state_q <= StCalc1;
                    end
                end
                StCalc1: begin
                    prod_q  <= ProdW'(diff_q) * ProdW'(scale_q);
                    state_q <= StCalc2;
                end
                StCalc2: begin
                    out_q   <= res_sat;
                    clip_q  <= clip_pos || clip_neg;
                    state_q <= StIssue;
                end
                StIssue: begin
                    // Registered pulse: visible in the cycle after the ISSUE edge, word already stable.
                    in_ready_q  <= 1'b1;
                    sat_pulse_q <= clip_q;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (nlc.x_output_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign nlc.x_centered_scaled          = out_q;
    assign nlc.x_centered_scaled_in_ready = in_ready_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign saturated  = sat_pulse_q;
    assign busy       = (state_q != StIdle);
endmodule
